// File: rtl/fir_128_mdc_seq_pkg.sv
// Shared types for the FIR-128 MDC tile sequencer: FSM states, the
// decoded control bundle and the per-tile handshake flags.
package fir_128_mdc_package;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        RUN,
        NEXT,
        FIN
    } seq_state_t;

    // Outputs decoded from the current state and flags
    typedef struct packed {
        logic src_req;
        logic snk_req;
        logic busy;
        logic done;
    } ctrl_seq_t;

    // Sticky per-tile handshake flags, cleared between tiles
    typedef struct packed {
        logic src_ack;
        logic snk_ack;
        logic src_done;
        logic snk_done;
    } flags_seq_t;

endpackage

// File: rtl/fir_128_mdc_seq_addr.sv
// Per-stream address generator: load latches base and stride, step
// advances the address by the stride (wrapping modulo 2^ADDR_W).
module fir_128_mdc_seq_addr #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] stride_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;

    // Next address: load has priority over step
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        addr_d   = addr_q;
        stride_d = stride_q;
        if (load_i) begin
            addr_d   = base_i;
            stride_d = stride_i;
        end else if (step_i) begin
            addr_d = addr_q + stride_q;
        end
    end

    // Address and stride registers with synchronous reset
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking (<=) so all flops update together at the edge.
        if (rst_i) begin
            addr_q   <= '0;
            stride_q <= '0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/fir_128_mdc_seq.sv
// FIR-128 MDC tile sequencer: for each tile, issues a source (x_V) and
// sink (y_V) request, starts the engine once both are accepted, waits for
// both transfers and the expected y_V beat count, then moves to the next
// tile with stride-advanced addresses.
module fir_128_mdc_seq
    import fir_128_mdc_package::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32,
    parameter int TILE_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [TILE_W-1:0] nb_tiles_i,
    input  logic [ADDR_W-1:0] x_base_i,
    input  logic [ADDR_W-1:0] y_base_i,
    input  logic [ADDR_W-1:0] x_stride_i,
    input  logic [ADDR_W-1:0] y_stride_i,
    input  logic [CNT_W-1:0]  x_size_i,
    input  logic [CNT_W-1:0]  y_size_i,
    input  logic [CNT_W-1:0]  cnt_limit_i,
    output logic              src_req_o,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [CNT_W-1:0]  src_size_o,
    input  logic              src_ack_i,
    input  logic              src_done_i,
    output logic              snk_req_o,
    output logic [ADDR_W-1:0] snk_addr_o,
    output logic [CNT_W-1:0]  snk_size_o,
    input  logic              snk_ack_i,
    input  logic              snk_done_i,
    output logic              eng_start_o,
    input  logic              y_valid_i,
    input  logic              y_ready_i,
    output logic              busy_o,
    output logic [TILE_W-1:0] tile_idx_o,
    output logic              done_o,
    output logic              ovf_o
);

    seq_state_t        state_q, state_d;
    flags_seq_t        flags_q, flags_d;
    ctrl_seq_t         ctrl;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [TILE_W-1:0] nb_tiles_q, nb_tiles_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  limit_q, limit_d;
    logic [CNT_W-1:0]  x_size_q, x_size_d;
    logic [CNT_W-1:0]  y_size_q, y_size_d;
    logic              ovf_q, ovf_d;
    logic              eng_start_q, eng_start_d;

    logic sync_rst;
    logic beat;
    logic addr_load;
    logic addr_step;

    assign sync_rst  = rst_i | clear_i;
    assign beat      = y_valid_i & y_ready_i;
    assign addr_load = (state_q == IDLE) && start_i;
    assign addr_step = (state_q == NEXT) && (tile_q != nb_tiles_q);

    fir_128_mdc_seq_addr #(.ADDR_W(ADDR_W)) u_x_addr (
        .clk_i    (clk_i),
        .rst_i    (sync_rst),
        .load_i   (addr_load),
        .step_i   (addr_step),
        .base_i   (x_base_i),
        .stride_i (x_stride_i),
        .addr_o   (src_addr_o)
    );

    fir_128_mdc_seq_addr #(.ADDR_W(ADDR_W)) u_y_addr (
        .clk_i    (clk_i),
        .rst_i    (sync_rst),
        .load_i   (addr_load),
        .step_i   (addr_step),
        .base_i   (y_base_i),
        .stride_i (y_stride_i),
        .addr_o   (snk_addr_o)
    );

    // Next-state logic: handshake flags, beat counter and tile sequencing
    always_comb begin
        state_d     = state_q;
        flags_d     = flags_q;
        tile_d      = tile_q;
        nb_tiles_d  = nb_tiles_q;
        count_d     = count_q;
        limit_d     = limit_q;
        x_size_d    = x_size_q;
        y_size_d    = y_size_q;
        ovf_d       = ovf_q;
        eng_start_d = 1'b0;

        // Done pulses are remembered in any active state and in any order
        if (state_q != IDLE) begin
            flags_d.src_done = flags_q.src_done | src_done_i;
            flags_d.snk_done = flags_q.snk_done | snk_done_i;
        end

        // Acks only matter while the requests are outstanding
        if (state_q == ISSUE) begin
            flags_d.src_ack = flags_q.src_ack | src_ack_i;
            flags_d.snk_ack = flags_q.snk_ack | snk_ack_i;
        end

        // Beat counter saturates at the limit; an extra beat flags overrun
        if (((state_q == ISSUE) || (state_q == RUN)) && beat) begin
            if (count_q == limit_q) begin
                if (limit_q != '0) begin
                    ovf_d = 1'b1;
                end
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    nb_tiles_d = nb_tiles_i;
                    limit_d    = cnt_limit_i;
                    x_size_d   = x_size_i;
                    y_size_d   = y_size_i;
                    tile_d     = '0;
                    count_d    = '0;
                    flags_d    = '0;
                    ovf_d      = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (flags_d.src_ack && flags_d.snk_ack) begin
                    eng_start_d = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (flags_q.src_done && flags_q.snk_done && (count_q >= limit_q)) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                flags_d = '0;
                count_d = '0;
                if (tile_q == nb_tiles_q) begin
                    state_d = FIN;
                end else begin
                    tile_d  = tile_q + 1'b1;
                    state_d = ISSUE;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the registered state and flags
    always_comb begin
        ctrl         = '0;
        ctrl.src_req = (state_q == ISSUE) && !flags_q.src_ack;
        ctrl.snk_req = (state_q == ISSUE) && !flags_q.snk_ack;
        ctrl.busy    = (state_q != IDLE);
        ctrl.done    = (state_q == FIN);
    end

    // State register; rst_i and clear_i both return everything to zero
    always_ff @(posedge clk_i) begin
        if (sync_rst) begin
            state_q     <= IDLE;
            flags_q     <= '0;
            tile_q      <= '0;
            nb_tiles_q  <= '0;
            count_q     <= '0;
            limit_q     <= '0;
            x_size_q    <= '0;
            y_size_q    <= '0;
            ovf_q       <= 1'b0;
            eng_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            tile_q      <= tile_d;
            nb_tiles_q  <= nb_tiles_d;
            count_q     <= count_d;
            limit_q     <= limit_d;
            x_size_q    <= x_size_d;
            y_size_q    <= y_size_d;
            ovf_q       <= ovf_d;
            eng_start_q <= eng_start_d;
        end
    end

    assign src_req_o   = ctrl.src_req;
    assign snk_req_o   = ctrl.snk_req;
    assign busy_o      = ctrl.busy;
    assign done_o      = ctrl.done;
    assign src_size_o  = x_size_q;
    assign snk_size_o  = y_size_q;
    assign eng_start_o = eng_start_q;
    assign tile_idx_o  = tile_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_fir_128_mdc_seq.sv
// Directed bench for the FIR-128 MDC tile sequencer. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_fir_128_mdc_seq;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 32;
    localparam int TILE_W = 12;

    logic              clk_i = 1'b0;
    logic              rst_i, clear_i, start_i;
    logic [TILE_W-1:0] nb_tiles_i;
    logic [ADDR_W-1:0] x_base_i, y_base_i, x_stride_i, y_stride_i;
    logic [CNT_W-1:0]  x_size_i, y_size_i, cnt_limit_i;
    logic              src_req_o, snk_req_o, src_ack_i, snk_ack_i, src_done_i, snk_done_i;
    logic [ADDR_W-1:0] src_addr_o, snk_addr_o;
    logic [CNT_W-1:0]  src_size_o, snk_size_o;
    logic              eng_start_o, y_valid_i, y_ready_i, busy_o, done_o, ovf_o;
    logic [TILE_W-1:0] tile_idx_o;

    int n_checks = 0;
    int n_pass   = 0;
    int done_pulses = 0;
    int eng_pulses  = 0;
    int done_mark, eng_mark;

    always #5 clk_i = ~clk_i;

    fir_128_mdc_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TILE_W(TILE_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .start_i     (start_i),
        .nb_tiles_i  (nb_tiles_i),
        .x_base_i    (x_base_i),
        .y_base_i    (y_base_i),
        .x_stride_i  (x_stride_i),
        .y_stride_i  (y_stride_i),
        .x_size_i    (x_size_i),
        .y_size_i    (y_size_i),
        .cnt_limit_i (cnt_limit_i),
        .src_req_o   (src_req_o),
        .src_addr_o  (src_addr_o),
        .src_size_o  (src_size_o),
        .src_ack_i   (src_ack_i),
        .src_done_i  (src_done_i),
        .snk_req_o   (snk_req_o),
        .snk_addr_o  (snk_addr_o),
        .snk_size_o  (snk_size_o),
        .snk_ack_i   (snk_ack_i),
        .snk_done_i  (snk_done_i),
        .eng_start_o (eng_start_o),
        .y_valid_i   (y_valid_i),
        .y_ready_i   (y_ready_i),
        .busy_o      (busy_o),
        .tile_idx_o  (tile_idx_o),
        .done_o      (done_o),
        .ovf_o       (ovf_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one cycle and tally single-cycle output pulses
    task automatic tick();
        @(negedge clk_i);
        if (done_o)      done_pulses++;
        if (eng_start_o) eng_pulses++;
    endtask

    task automatic configure(input logic [TILE_W-1:0] nb, input logic [ADDR_W-1:0] xb,
                             input logic [ADDR_W-1:0] xs, input logic [ADDR_W-1:0] yb,
                             input logic [ADDR_W-1:0] ys, input logic [CNT_W-1:0] lim);
        nb_tiles_i  = nb;
        x_base_i    = xb;
        x_stride_i  = xs;
        y_base_i    = yb;
        y_stride_i  = ys;
        cnt_limit_i = lim;
        x_size_i    = 32'd128;
        y_size_i    = 32'd128;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic ack_both();
        src_ack_i = 1'b1;
        snk_ack_i = 1'b1;
        tick();
        src_ack_i = 1'b0;
        snk_ack_i = 1'b0;
    endtask

    task automatic done_both();
        src_done_i = 1'b1;
        snk_done_i = 1'b1;
        tick();
        src_done_i = 1'b0;
        snk_done_i = 1'b0;
    endtask

    task automatic beats(input int n);
        y_valid_i = 1'b1;
        y_ready_i = 1'b1;
        for (int i = 0; i < n; i++) tick();
        y_valid_i = 1'b0;
        y_ready_i = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !(src_req_o && snk_req_o); i++) tick();
        check(tag, {src_req_o, snk_req_o}, 2'b11);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && !done_o; i++) tick();
        check(tag, done_o, 1'b1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; clear_i = 1'b0; start_i = 1'b0;
        src_ack_i = 1'b0; snk_ack_i = 1'b0; src_done_i = 1'b0; snk_done_i = 1'b0;
        y_valid_i = 1'b0; y_ready_i = 1'b0;
        configure('0, '0, '0, '0, '0, '0);

        // Reset state
        do_reset();
        check("rst_busy", busy_o, 1'b0);
        check("rst_reqs", {src_req_o, snk_req_o}, 2'b00);
        check("rst_pulses", {eng_start_o, done_o, ovf_o}, 3'b000);
        check("rst_tile", tile_idx_o, 0);
        check("rst_addr", {src_addr_o, snk_addr_o}, 64'h0);

        // Single tile, limit 127, acks immediately
        configure(12'd0, 32'h100, 32'h0, 32'h800, 32'h0, 32'd127);
        eng_mark = eng_pulses;
        done_mark = done_pulses;
        pulse_start();
        check("t1_reqs", {src_req_o, snk_req_o}, 2'b11);
        check("t1_src_addr", src_addr_o, 32'h100);
        check("t1_snk_addr", snk_addr_o, 32'h800);
        check("t1_busy", busy_o, 1'b1);
        check("t1_eng_early", eng_start_o, 1'b0);
        ack_both();
        check("t1_eng_start", eng_start_o, 1'b1);
        check("t1_reqs_drop", {src_req_o, snk_req_o}, 2'b00);
        tick();
        check("t1_eng_one_cycle", eng_start_o, 1'b0);
        beats(126);
        done_both();
        tick();
        tick();
        check("t1_wait_beats_done", done_o, 1'b0);
        check("t1_wait_beats_busy", busy_o, 1'b1);
        beats(1);
        wait_done("t1_done");
        tick();
        check("t1_done_one_cycle", done_o, 1'b0);
        check("t1_idle", busy_o, 1'b0);
        check("t1_ovf", ovf_o, 1'b0);
        check("t1_eng_count", eng_pulses - eng_mark, 1);
        check("t1_done_count", done_pulses - done_mark, 1);

        // Four tiles, address sequence; a stray start in RUN is ignored
        configure(12'd3, 32'h1000, 32'h200, 32'h2000, 32'h40, 32'd0);
        done_mark = done_pulses;
        pulse_start();
        for (int t = 0; t < 4; t++) begin
            wait_req($sformatf("t2_req%0d", t));
            check($sformatf("t2_src_addr%0d", t), src_addr_o, 32'h1000 + 32'h200 * t);
            check($sformatf("t2_snk_addr%0d", t), snk_addr_o, 32'h2000 + 32'h40 * t);
            check($sformatf("t2_tile%0d", t), tile_idx_o, t);
            ack_both();
            if (t == 1) pulse_start();
            done_both();
        end
        check("t2_sizes", {src_size_o, snk_size_o}, {32'd128, 32'd128});
        wait_done("t2_done");
        tick();
        check("t2_idle", busy_o, 1'b0);
        check("t2_done_count", done_pulses - done_mark, 1);

        // Skewed handshakes: snk_ack 5 cycles after src_ack, snk_done first
        configure(12'd0, 32'h3000, 32'h0, 32'h4000, 32'h0, 32'd2);
        eng_mark = eng_pulses;
        pulse_start();
        src_ack_i = 1'b1;
        tick();
        src_ack_i = 1'b0;
        check("t3_src_req_drop", src_req_o, 1'b0);
        check("t3_snk_req_hold", snk_req_o, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("t3_snk_req_still", snk_req_o, 1'b1);
        check("t3_snk_addr_stable", snk_addr_o, 32'h4000);
        check("t3_no_eng_yet", eng_pulses - eng_mark, 0);
        snk_ack_i = 1'b1;
        tick();
        snk_ack_i = 1'b0;
        check("t3_eng_start", eng_start_o, 1'b1);
        snk_done_i = 1'b1;
        tick();
        snk_done_i = 1'b0;
        beats(2);
        src_done_i = 1'b1;
        tick();
        src_done_i = 1'b0;
        wait_done("t3_done");
        tick();
        check("t3_idle", busy_o, 1'b0);
        check("t3_eng_count", eng_pulses - eng_mark, 1);

        // Overrun: limit 4, five beats
        configure(12'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd4);
        pulse_start();
        ack_both();
        beats(4);
        check("t4_no_ovf_at_limit", ovf_o, 1'b0);
        beats(1);
        check("t4_ovf_set", ovf_o, 1'b1);
        done_both();
        wait_done("t4_done");
        tick();
        check("t4_ovf_held_idle", ovf_o, 1'b1);
        configure(12'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd0);
        pulse_start();
        check("t4_ovf_cleared", ovf_o, 1'b0);
        ack_both();
        done_both();
        wait_done("t4b_done");
        tick();

        // Mid-job clear in RUN of tile 2, with start and dones in the same cycle
        configure(12'd3, 32'h1000, 32'h200, 32'h2000, 32'h40, 32'd0);
        pulse_start();
        for (int t = 0; t < 2; t++) begin
            wait_req($sformatf("t5_req%0d", t));
            ack_both();
            done_both();
        end
        wait_req("t5_req2");
        ack_both();
        check("t5_tile2", tile_idx_o, 2);
        clear_i = 1'b1; start_i = 1'b1; src_done_i = 1'b1; snk_done_i = 1'b1;
        tick();
        clear_i = 1'b0; start_i = 1'b0; src_done_i = 1'b0; snk_done_i = 1'b0;
        check("t5_clr_busy", busy_o, 1'b0);
        check("t5_clr_reqs", {src_req_o, snk_req_o}, 2'b00);
        check("t5_clr_pulses", {eng_start_o, done_o, ovf_o}, 3'b000);
        check("t5_clr_tile", tile_idx_o, 0);
        check("t5_clr_addr", {src_addr_o, snk_addr_o}, 64'h0);
        tick();
        check("t5_start_ignored", busy_o, 1'b0);
        pulse_start();
        check("t5_restart_tile", tile_idx_o, 0);
        check("t5_restart_addr", src_addr_o, 32'h1000);
        check("t5_restart_req", src_req_o, 1'b1);
        do_reset();

        // Address wrap modulo 2^32
        configure(12'd1, 32'hFFFF_FF00, 32'h200, 32'h0, 32'h10, 32'd0);
        pulse_start();
        check("t6_addr0", src_addr_o, 32'hFFFF_FF00);
        ack_both();
        done_both();
        wait_req("t6_req1");
        check("t6_addr1_wrap", src_addr_o, 32'h0000_0100);
        check("t6_tile1", tile_idx_o, 1);
        ack_both();
        done_both();
        wait_done("t6_done");
        tick();
        check("t6_idle", busy_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
